inst_buffer: RTL and testbench
==============================

Name: inst_buffer

Overview:
- Circular instruction queue between the fetch stage (producer) and the dual-issue decode/issue stage (consumer).
- Accepts at most one fetched word per cycle.
- Presents the two oldest entries in show-ahead form; decode pops 0, 1 or 2 entries per cycle.
- Drives the almost-full back-pressure that fetch uses to gate its instruction-memory enable, and drains completely on pipeline flush.

Parameters:
- DEPTH, 16: number of entries; must be a power of two and at least 4.
- AW, 4: pointer width, equal to log2(DEPTH).
- FULL_MARGIN, 2: free-slot reserve that absorbs fetches already in flight when full asserts.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  synchronous, active-high reset. The name is kept for codebase consistency; asserted = 1.
- flush  in  1  exception/redirect flush; empties the queue.
- wr_en  in  1  fetch returns a valid word this cycle.
- wr_pc  in  32  address of the written word.
- wr_inst  in  32  instruction word.
- wr_exccode  in  5  fetch exception code (EXC_NONE when clean).
- rd_num  in  2  entries decode consumes this cycle: 0, 1 or 2 (3 treated as 2).
- inst1_valid  out  1  head entry present.
- inst1_pc  out  32  head entry pc.
- inst1  out  32  head entry instruction.
- inst1_exccode  out  5  head entry exception code.
- inst2_valid  out  1  second entry present.
- inst2_pc  out  32  second entry pc.
- inst2  out  32  second entry instruction.
- inst2_exccode  out  5  second entry exception code.
- count  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  almost-full; routed to fetch as instBufferFull.
- overflow  out  1  sticky error: a write arrived while count == DEPTH.

Behaviour:
- State: storage array of DEPTH x 69 bits {pc, inst, exccode}, head pointer, tail pointer (both AW bits, wrapping modulo DEPTH), and count register.
- Reset (resetn = 1 at clk edge): head = tail = 0, count = 0, overflow = 0. All valids = 0, full = 0. Data outputs read array contents; they are don't-care while the corresponding valid = 0. The array itself is not cleared.
- Flush (reset inactive, flush = 1): head = tail = 0 and count = 0 at the next edge. wr_en and rd_num are ignored that cycle. overflow is preserved. Flush takes priority over every other event.
- Read side is combinational show-ahead:
  - inst1_* = entry[head]; inst1_valid = (count >= 1).
  - inst2_* = entry[head+1 mod DEPTH]; inst2_valid = (count >= 2).
- Pop amount:
  - pop = min(rd_num clamped to 2, count), where count is the pre-edge occupancy.
  - A write in the same cycle does not count toward poppable entries (no write-to-read bypass).
  - head advances by pop.
- Write:
  - If wr_en = 1 and count < DEPTH: entry[tail] is written, tail advances by 1, and the word is visible on the read ports the cycle after the write.
  - If wr_en = 1 and count == DEPTH: the write is dropped, overflow is set, and tail is unchanged.
- Occupancy: count_next = count + push - pop, with push in {0,1} and pop in {0,1,2}. A simultaneous push and pop at count == DEPTH is legal only when pop >= 1 frees a slot before the edge; in that case push is accepted.
- full is combinational: count >= DEPTH - FULL_MARGIN.
  - Fetch deasserts its enable when full = 1. One word may still return one cycle later; the margin absorbs it.
  - Overflow therefore indicates a protocol violation and is never expected in normal operation.
- Wrap-around: pointers roll from DEPTH-1 to 0. inst2 at head = DEPTH-1 reads entry 0.
- Ordering: strict FIFO. Entries carry exccode untouched; the buffer never interprets it.

Test Plan:
- Reset, then write pc 0xBFC00000..0xBFC0000C (4 words) with rd_num = 0 -> count = 4, inst1_pc = 0xBFC00000, inst2_pc = 0xBFC00004, full = 0.
- From count = 4, apply rd_num = 2 for one cycle with no write -> count = 2, inst1_pc = 0xBFC00008. Then rd_num = 2 with count = 1 -> pop = 1, count = 0, both valids 0.
- Fill to 14 (DEPTH = 16) -> full asserts at count 14. Write 2 more -> count = 16, overflow = 0. A 17th write -> dropped, overflow = 1, count stays 16.
- Empty buffer: wr_en = 1 with rd_num = 2 in the same cycle -> pop = 0, count = 1; the entry appears on inst1 the next cycle.
- Run 40 sequential words through with alternating rd_num 1/2 -> output pc order strictly increasing by 4 across pointer wrap; inst2 correct when head = 15.
- Count = 9, assert flush together with wr_en = 1 and rd_num = 2 -> next cycle count = 0, valids 0, full = 0. The written word is discarded, and overflow keeps its prior value.

Source files
------------

// File: rtl/inst_buffer_if.sv
// Fetch/decode-facing signal bundle for the instruction buffer.
// master = pipeline side, slave = buffer side.
interface inst_buffer_if #(
   parameter int AW = 4
);
   logic        flush;
   logic        wr_en;
   logic [31:0] wr_pc;
   logic [31:0] wr_inst;
   logic [4:0]  wr_exccode;
   logic [1:0]  rd_num;
   logic        inst1_valid;
   logic [31:0] inst1_pc;
   logic [31:0] inst1;
   logic [4:0]  inst1_exccode;
   logic        inst2_valid;
   logic [31:0] inst2_pc;
   logic [31:0] inst2;
   logic [4:0]  inst2_exccode;
   logic [AW:0] count;
   logic        full;
   logic        overflow;

   modport master (
      output flush, wr_en, wr_pc, wr_inst,
      output wr_exccode, rd_num,
      input  inst1_valid, inst1_pc, inst1,
      input  inst1_exccode,
      input  inst2_valid, inst2_pc, inst2,
      input  inst2_exccode,
      input  count, full, overflow
   );

   modport slave (
      input  flush, wr_en, wr_pc, wr_inst,
      input  wr_exccode, rd_num,
      output inst1_valid, inst1_pc, inst1,
      output inst1_exccode,
      output inst2_valid, inst2_pc, inst2,
      output inst2_exccode,
      output count, full, overflow
   );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction queue: one push per cycle, show-ahead
// dual read with 0/1/2 pops, almost-full back-pressure.
module inst_buffer #(
   parameter int DEPTH       = 16,
   parameter int AW          = 4,
   parameter int FULL_MARGIN = 2
) (
   input logic          clk,
   input logic          resetn,
   inst_buffer_if.slave ib
);
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  exccode;
   } entry_t;

   localparam logic [AW:0] DEPTH_C =
      (AW+1)'(DEPTH);
   localparam logic [AW:0] FULL_TH =
      (AW+1)'(DEPTH - FULL_MARGIN);
   localparam logic [AW:0] TWO =
      (AW+1)'(2);

   entry_t        mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] head2;
   logic [AW:0]   cnt;
   logic [AW:0]   cnt_nxt;
   logic [AW:0]   pop;
   logic [1:0]    rd_c;
   logic          push;
   logic          drop;
   logic          ovf;

   // Pops only see pre-edge occupancy; a same-cycle write
   // is never poppable.
   always_comb begin
      rd_c = ib.rd_num;
      if (ib.rd_num == 2'd3) rd_c = 2'd2;
      pop = (AW+1)'(rd_c);
      if (cnt < pop) pop = cnt;
      push = ib.wr_en &&
             (cnt != DEPTH_C || pop != '0);
      drop = ib.wr_en && !push;
      cnt_nxt = cnt + (AW+1)'(push) - pop;
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         ovf  <= 1'b0;
      end else if (ib.flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         head <= head + pop[AW-1:0];
         if (push) tail <= tail + AW'(1);
         cnt <= cnt_nxt;
         if (drop) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn && !ib.flush && push) begin
         mem[tail] <= '{pc:      ib.wr_pc,
                        inst:    ib.wr_inst,
                        exccode: ib.wr_exccode};
      end
   end

   assign head2 = head + AW'(1);

   assign ib.inst1_valid   = cnt != '0;
   assign ib.inst1_pc      = mem[head].pc;
   assign ib.inst1         = mem[head].inst;
   assign ib.inst1_exccode = mem[head].exccode;
   assign ib.inst2_valid   = cnt >= TWO;
   assign ib.inst2_pc      = mem[head2].pc;
   assign ib.inst2         = mem[head2].inst;
   assign ib.inst2_exccode = mem[head2].exccode;
   assign ib.count         = cnt;
   assign ib.full          = cnt >= FULL_TH;
   assign ib.overflow      = ovf;
endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: fill, pop, full/overflow,
// no-bypass, wrap streaming and flush.
module tb_inst_buffer;
   logic clk = 1'b0;
   logic resetn;
   int   errors = 0;
   int   checks = 0;

   inst_buffer_if #(.AW(4)) ib ();

   inst_buffer #(
      .DEPTH(16), .AW(4), .FULL_MARGIN(2)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .ib(ib)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ib.flush      = 1'b0;
      ib.wr_en      = 1'b0;
      ib.wr_pc      = '0;
      ib.wr_inst    = '0;
      ib.wr_exccode = '0;
      ib.rd_num     = 2'd0;
   endtask

   task automatic do_reset();
      idle();
      resetn = 1'b1;
      tick();
      resetn = 1'b0;
   endtask

   task automatic wr(input logic [31:0] pc,
                     input logic [1:0] rd);
      ib.wr_en      = 1'b1;
      ib.wr_pc      = pc;
      ib.wr_inst    = ~pc;
      ib.wr_exccode = pc[6:2];
      ib.rd_num     = rd;
      tick();
      idle();
   endtask

   task automatic rd(input logic [1:0] n);
      ib.rd_num = n;
      tick();
      idle();
   endtask

   task automatic test_reset();
      do_reset();
      checks += 5;
      if (ib.count !== 5'd0) begin
         errors++;
         $display("FAIL reset_count got %0d want 0",
                  ib.count);
      end
      if (ib.inst1_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_v1 got %b want 0",
                  ib.inst1_valid);
      end
      if (ib.inst2_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_v2 got %b want 0",
                  ib.inst2_valid);
      end
      if (ib.full !== 1'b0) begin
         errors++;
         $display("FAIL reset_full got %b want 0",
                  ib.full);
      end
      if (ib.overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovf got %b want 0",
                  ib.overflow);
      end
   endtask

   task automatic test_fill4();
      do_reset();
      for (int i = 0; i < 4; i++)
         wr(32'hBFC0_0000 + 32'(4 * i), 2'd0);
      checks += 6;
      if (ib.count !== 5'd4) begin
         errors++;
         $display("FAIL fill4_count got %0d want 4",
                  ib.count);
      end
      if (ib.inst1_pc !== 32'hBFC0_0000) begin
         errors++;
         $display("FAIL fill4_pc1 got %h want bfc00000",
                  ib.inst1_pc);
      end
      if (ib.inst2_pc !== 32'hBFC0_0004) begin
         errors++;
         $display("FAIL fill4_pc2 got %h want bfc00004",
                  ib.inst2_pc);
      end
      if (ib.inst1 !== 32'h403F_FFFF) begin
         errors++;
         $display("FAIL fill4_inst1 got %h want 403fffff",
                  ib.inst1);
      end
      if (ib.inst2_exccode !== 5'd1) begin
         errors++;
         $display("FAIL fill4_exc2 got %0d want 1",
                  ib.inst2_exccode);
      end
      if (ib.full !== 1'b0) begin
         errors++;
         $display("FAIL fill4_full got %b want 0",
                  ib.full);
      end
   endtask

   task automatic test_pop();
      rd(2'd2);
      checks += 2;
      if (ib.count !== 5'd2) begin
         errors++;
         $display("FAIL pop2_count got %0d want 2",
                  ib.count);
      end
      if (ib.inst1_pc !== 32'hBFC0_0008) begin
         errors++;
         $display("FAIL pop2_pc1 got %h want bfc00008",
                  ib.inst1_pc);
      end
      rd(2'd1);
      checks += 2;
      if (ib.count !== 5'd1) begin
         errors++;
         $display("FAIL pop1_count got %0d want 1",
                  ib.count);
      end
      if (ib.inst1_pc !== 32'hBFC0_000C) begin
         errors++;
         $display("FAIL pop1_pc1 got %h want bfc0000c",
                  ib.inst1_pc);
      end
      rd(2'd3);
      checks += 3;
      if (ib.count !== 5'd0) begin
         errors++;
         $display("FAIL popclamp_count got %0d want 0",
                  ib.count);
      end
      if (ib.inst1_valid !== 1'b0) begin
         errors++;
         $display("FAIL popclamp_v1 got %b want 0",
                  ib.inst1_valid);
      end
      if (ib.inst2_valid !== 1'b0) begin
         errors++;
         $display("FAIL popclamp_v2 got %b want 0",
                  ib.inst2_valid);
      end
   endtask

   task automatic test_no_bypass();
      wr(32'h0000_0200, 2'd2);
      checks += 3;
      if (ib.count !== 5'd1) begin
         errors++;
         $display("FAIL bypass_count got %0d want 1",
                  ib.count);
      end
      if (ib.inst1_valid !== 1'b1) begin
         errors++;
         $display("FAIL bypass_v1 got %b want 1",
                  ib.inst1_valid);
      end
      if (ib.inst1_pc !== 32'h0000_0200) begin
         errors++;
         $display("FAIL bypass_pc1 got %h want 00000200",
                  ib.inst1_pc);
      end
      rd(2'd1);
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 13; i++)
         wr(32'h100 + 32'(4 * i), 2'd0);
      checks++;
      if (ib.full !== 1'b0) begin
         errors++;
         $display("FAIL full13 got %b want 0", ib.full);
      end
      wr(32'h134, 2'd0);
      checks++;
      if (ib.full !== 1'b1) begin
         errors++;
         $display("FAIL full14 got %b want 1", ib.full);
      end
      wr(32'h138, 2'd0);
      wr(32'h13C, 2'd0);
      checks += 2;
      if (ib.count !== 5'd16) begin
         errors++;
         $display("FAIL full16_count got %0d want 16",
                  ib.count);
      end
      if (ib.overflow !== 1'b0) begin
         errors++;
         $display("FAIL full16_ovf got %b want 0",
                  ib.overflow);
      end
      wr(32'h140, 2'd0);
      checks += 3;
      if (ib.count !== 5'd16) begin
         errors++;
         $display("FAIL ovf_count got %0d want 16",
                  ib.count);
      end
      if (ib.overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_flag got %b want 1",
                  ib.overflow);
      end
      if (ib.inst1_pc !== 32'h100) begin
         errors++;
         $display("FAIL ovf_pc1 got %h want 00000100",
                  ib.inst1_pc);
      end
      wr(32'h144, 2'd1);
      checks += 2;
      if (ib.count !== 5'd16) begin
         errors++;
         $display("FAIL pushpop_count got %0d want 16",
                  ib.count);
      end
      if (ib.inst1_pc !== 32'h104) begin
         errors++;
         $display("FAIL pushpop_pc1 got %h want 00000104",
                  ib.inst1_pc);
      end
      for (int i = 0; i < 7; i++) rd(2'd2);
      checks += 3;
      if (ib.count !== 5'd2) begin
         errors++;
         $display("FAIL drain_count got %0d want 2",
                  ib.count);
      end
      if (ib.inst1_pc !== 32'h13C) begin
         errors++;
         $display("FAIL drain_pc1 got %h want 0000013c",
                  ib.inst1_pc);
      end
      if (ib.inst2_pc !== 32'h144) begin
         errors++;
         $display("FAIL drain_pc2 got %h want 00000144",
                  ib.inst2_pc);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 7; i++)
         wr(32'h300 + 32'(4 * i), 2'd0);
      checks++;
      if (ib.count !== 5'd9) begin
         errors++;
         $display("FAIL preflush_count got %0d want 9",
                  ib.count);
      end
      ib.flush      = 1'b1;
      ib.wr_en      = 1'b1;
      ib.wr_pc      = 32'h400;
      ib.rd_num     = 2'd2;
      tick();
      idle();
      checks += 5;
      if (ib.count !== 5'd0) begin
         errors++;
         $display("FAIL flush_count got %0d want 0",
                  ib.count);
      end
      if (ib.inst1_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_v1 got %b want 0",
                  ib.inst1_valid);
      end
      if (ib.inst2_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_v2 got %b want 0",
                  ib.inst2_valid);
      end
      if (ib.full !== 1'b0) begin
         errors++;
         $display("FAIL flush_full got %b want 0",
                  ib.full);
      end
      if (ib.overflow !== 1'b1) begin
         errors++;
         $display("FAIL flush_ovf got %b want 1",
                  ib.overflow);
      end
      wr(32'h500, 2'd0);
      checks++;
      if (ib.inst1_pc !== 32'h500) begin
         errors++;
         $display("FAIL postflush_pc1 got %h want 00000500",
                  ib.inst1_pc);
      end
      do_reset();
      checks++;
      if (ib.overflow !== 1'b0) begin
         errors++;
         $display("FAIL rst_ovf got %b want 0",
                  ib.overflow);
      end
   endtask

   task automatic test_stream();
      int          exp_cnt;
      int          sent;
      int          got;
      int          pop;
      int          cyc;
      logic [1:0]  n;
      logic [31:0] exp_pc;
      do_reset();
      for (int i = 0; i < 12; i++)
         wr(32'h1000 + 32'(4 * i), 2'd0);
      exp_cnt = 12;
      sent    = 12;
      got     = 0;
      exp_pc  = 32'h1000;
      cyc     = 0;
      while (got < 40 && cyc < 200) begin
         n = (cyc % 2 == 0) ? 2'd1 : 2'd2;
         checks++;
         if (ib.count !== 5'(exp_cnt)) begin
            errors++;
            $display("FAIL stream_count c%0d got %0d want %0d",
                     cyc, ib.count, exp_cnt);
         end
         if (exp_cnt >= 1) begin
            checks += 2;
            if (ib.inst1_pc !== exp_pc) begin
               errors++;
               $display("FAIL stream_pc1 c%0d got %h want %h",
                        cyc, ib.inst1_pc, exp_pc);
            end
            if (ib.inst1 !== ~exp_pc) begin
               errors++;
               $display("FAIL stream_inst1 c%0d got %h want %h",
                        cyc, ib.inst1, ~exp_pc);
            end
         end
         if (exp_cnt >= 2) begin
            checks++;
            if (ib.inst2_pc !== exp_pc + 32'd4) begin
               errors++;
               $display("FAIL stream_pc2 c%0d got %h want %h",
                        cyc, ib.inst2_pc, exp_pc + 32'd4);
            end
         end
         pop = (exp_cnt < int'(n)) ? exp_cnt : int'(n);
         ib.rd_num = n;
         if (sent < 40) begin
            ib.wr_en      = 1'b1;
            ib.wr_pc      = 32'h1000 + 32'(4 * sent);
            ib.wr_inst    = ~ib.wr_pc;
            ib.wr_exccode = ib.wr_pc[6:2];
            sent++;
            exp_cnt++;
         end
         tick();
         idle();
         exp_cnt -= pop;
         got     += pop;
         exp_pc  += 32'(4 * pop);
         cyc++;
      end
      checks++;
      if (got != 40) begin
         errors++;
         $display("FAIL stream_timeout got %0d want 40", got);
      end
   endtask

   initial begin
      resetn = 1'b1;
      idle();
      test_reset();
      test_fill4();
      test_pop();
      test_no_bypass();
      test_full();
      test_flush();
      test_stream();
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end
endmodule
